// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and strobe sequencer for an external async SRAM
module sram_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              h_req_i,
  input  logic              h_we_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [DATA_W-1:0] h_wdata_i,
  output logic [DATA_W-1:0] h_rdata_o,
  output logic              h_ack_o,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_ack_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_out_o,
  output logic              mem_data_oe_o,
  input  logic [DATA_W-1:0] mem_data_in_i,
  output logic              ceh_n_o,
  output logic              ce2_o,
  output logic              we_n_o,
  output logic              oe_n_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  // Strobe counter reloads with WAIT_CYCLES-1 so that reaching zero marks the last strobe cycle.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                gnt_q, gnt_d;      // 0 = host, 1 = aux
  logic                last_q, last_d;    // port granted most recently
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_out_q, mem_data_out_d;
  logic                mem_data_oe_q, mem_data_oe_d;
  logic                ceh_n_q, ceh_n_d;
  logic                ce2_q, ce2_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic [DATA_W-1:0]   h_rdata_q, h_rdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic                h_ack_q, h_ack_d;
  logic                a_ack_q, a_ack_d;
  logic                grant;
  logic                grant_aux;
  logic                strobe_last;
  logic                active_d;

  // State register plus every registered output; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      gnt_q          <= 1'b0;
      last_q         <= 1'b1;
      we_q           <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_data_oe_q  <= 1'b0;
      ceh_n_q        <= 1'b1;
      ce2_q          <= 1'b0;
      we_n_q         <= 1'b1;
      oe_n_q         <= 1'b1;
      h_rdata_q      <= '0;
      a_rdata_q      <= '0;
      h_ack_q        <= 1'b0;
      a_ack_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gnt_q          <= gnt_d;
      last_q         <= last_d;
      we_q           <= we_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      mem_data_oe_q  <= mem_data_oe_d;
      ceh_n_q        <= ceh_n_d;
      ce2_q          <= ce2_d;
      we_n_q         <= we_n_d;
      oe_n_q         <= oe_n_d;
      h_rdata_q      <= h_rdata_d;
      a_rdata_q      <= a_rdata_d;
      h_ack_q        <= h_ack_d;
      a_ack_q        <= a_ack_d;
    end
  end

  // Next-state logic: round-robin grant in IDLE, then fixed SETUP/STROBE/HOLD sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    grant_aux = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (h_req_i || a_req_i) begin
          grant     = 1'b1;
          // On a tie the port that did not win last time gets the bus.
          grant_aux = a_req_i && (!h_req_i || !last_q);
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_LOAD;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign strobe_last = (state_q == S_STROBE) && (cnt_q == 4'd0);
  assign active_d    = (state_d != S_IDLE);

  // Output logic: next values of the registered pins, derived from the upcoming state.
  always_comb begin
    gnt_d          = grant ? grant_aux : gnt_q;
    last_d         = grant ? grant_aux : last_q;
    we_d           = grant ? (grant_aux ? a_we_i : h_we_i) : we_q;
    mem_address_d  = grant ? (grant_aux ? a_addr_i : h_addr_i) : mem_address_q;
    mem_data_out_d = grant ? (grant_aux ? a_wdata_i : h_wdata_i) : mem_data_out_q;
    ceh_n_d        = !active_d;
    ce2_d          = active_d;
    mem_data_oe_d  = active_d && we_d;
    we_n_d         = !((state_d == S_STROBE) && we_d);
    oe_n_d         = !((state_d == S_STROBE) && !we_d);
    h_ack_d        = (state_d == S_HOLD) && !gnt_d;
    a_ack_d        = (state_d == S_HOLD) && gnt_d;
    h_rdata_d      = h_rdata_q;
    a_rdata_d      = a_rdata_q;
    if (strobe_last && !we_q) begin
      if (gnt_q) begin
        a_rdata_d = mem_data_in_i;
      end else begin
        h_rdata_d = mem_data_in_i;
      end
    end
  end

  assign mem_address_o  = mem_address_q;
  assign mem_data_out_o = mem_data_out_q;
  assign mem_data_oe_o  = mem_data_oe_q;
  assign ceh_n_o        = ceh_n_q;
  assign ce2_o          = ce2_q;
  assign we_n_o         = we_n_q;
  assign oe_n_o         = oe_n_q;
  assign h_rdata_o      = h_rdata_q;
  assign a_rdata_o      = a_rdata_q;
  assign h_ack_o        = h_ack_q;
  assign a_ack_o        = a_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;

  logic        clk;
  logic        rst       [3];
  logic        h_req     [3];
  logic        h_we      [3];
  logic [16:0] h_addr    [3];
  logic [7:0]  h_wdata   [3];
  logic [7:0]  h_rdata   [3];
  logic        h_ack     [3];
  logic        a_req     [3];
  logic        a_we      [3];
  logic [16:0] a_addr    [3];
  logic [7:0]  a_wdata   [3];
  logic [7:0]  a_rdata   [3];
  logic        a_ack     [3];
  logic [16:0] mem_addr  [3];
  logic [7:0]  mem_dout  [3];
  logic        mem_oe    [3];
  logic [7:0]  mem_din   [3];
  logic        ceh_n     [3];
  logic        ce2       [3];
  logic        we_n      [3];
  logic        oe_n      [3];

  bit [7:0] sram    [3][256];
  bit       written [3][256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=2, instance 1: 1, instance 2: 15.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    sram_arbiter #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(W)) u_dut (
      .clk_i(clk), .reset_i(rst[g]),
      .h_req_i(h_req[g]), .h_we_i(h_we[g]), .h_addr_i(h_addr[g]), .h_wdata_i(h_wdata[g]),
      .h_rdata_o(h_rdata[g]), .h_ack_o(h_ack[g]),
      .a_req_i(a_req[g]), .a_we_i(a_we[g]), .a_addr_i(a_addr[g]), .a_wdata_i(a_wdata[g]),
      .a_rdata_o(a_rdata[g]), .a_ack_o(a_ack[g]),
      .mem_address_o(mem_addr[g]), .mem_data_out_o(mem_dout[g]), .mem_data_oe_o(mem_oe[g]),
      .mem_data_in_i(mem_din[g]),
      .ceh_n_o(ceh_n[g]), .ce2_o(ce2[g]), .we_n_o(we_n[g]), .oe_n_o(oe_n[g])
    );
    // Unwritten locations read back as low address byte XOR 8'h5A.
    assign mem_din[g] = oe_n[g] ? 8'h00 :
                        (written[g][mem_addr[g][7:0]] ? sram[g][mem_addr[g][7:0]]
                                                      : (mem_addr[g][7:0] ^ 8'h5A));
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!ceh_n[g] && ce2[g] && !we_n[g] && mem_oe[g]) begin
        sram[g][mem_addr[g][7:0]]    <= mem_dout[g];
        written[g][mem_addr[g][7:0]] <= 1'b1;
      end
    end
  end

  function automatic int wc(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; h_req[d] = 1'b0; h_we[d] = 1'b0; h_addr[d] = '0; h_wdata[d] = '0;
      a_req[d] = 1'b0; a_we[d] = 1'b0; a_addr[d] = '0; a_wdata[d] = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], h_ack[d], a_ack[d]} !== 7'b1011000) begin
        errors++;
        $display("FAIL reset_pins[%0d] got %b%b%b%b%b%b%b want 1011000", d,
                 ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], h_ack[d], a_ack[d]);
      end
      checks++;
      if ({mem_addr[d], mem_dout[d], h_rdata[d], a_rdata[d]} !== 41'd0) begin
        errors++;
        $display("FAIL reset_regs[%0d] got addr=%h dout=%h hr=%h ar=%h want all 0", d,
                 mem_addr[d], mem_dout[d], h_rdata[d], a_rdata[d]);
      end
      rst[d] = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int d = 0; d < 3; d++)
        if ({ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], h_ack[d], a_ack[d]} !== 7'b1011000)
          bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL idle_20 got activity=%b want 0", bad);
    end
  endtask

  task automatic do_access(input int d, input bit port, input bit we, input logic [16:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd);
    exp_t e;
    int w = wc(d);
    int strobe = 0;
    int wrong = 0;
    int ack_k = -1;
    bit overlap = 1'b0;
    bit got_port = 1'b0;
    bit both = 1'b0;
    logic [7:0] other_before, other_at_ack, rd_at_ack, dout_at_ack;
    logic [2:0] hold_pins;
    e.port = port; e.we = we; e.rdata = exp_rd;
    exp_q.push_back(e);
    other_before = port ? h_rdata[d] : a_rdata[d];
    if (port) begin
      a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wdata;
    end else begin
      h_req[d] = 1'b1; h_we[d] = we; h_addr[d] = addr; h_wdata[d] = wdata;
    end
    for (int k = 1; k <= w + 10 && ack_k < 0; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if ({ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], mem_addr[d]} !== {5'b01110 | {4'b0, we}, addr}) begin
          errors++;
          $display("FAIL setup[%0d] got ce=%b%b strobes=%b%b oe=%b addr=%h want ce=01 strobes=11 oe=%b addr=%h",
                   d, ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], mem_addr[d], we, addr);
        end
      end
      if (!we_n[d] && !oe_n[d]) overlap = 1'b1;
      if (we ? !we_n[d] : !oe_n[d]) strobe++;
      if (we ? !oe_n[d] : !we_n[d]) wrong++;
      if (h_ack[d] || a_ack[d]) begin
        ack_k        = k;
        got_port     = a_ack[d];
        both         = h_ack[d] && a_ack[d];
        rd_at_ack    = port ? a_rdata[d] : h_rdata[d];
        other_at_ack = port ? h_rdata[d] : a_rdata[d];
        dout_at_ack  = mem_dout[d];
        hold_pins    = {ceh_n[d], ce2[d], mem_oe[d]};
        if (port) a_req[d] = 1'b0; else h_req[d] = 1'b0;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (ack_k < 0) begin
      errors++;
      $display("FAIL ack_timeout[%0d] got no ack want ack at cycle %0d", d, w + 2);
      h_req[d] = 1'b0; a_req[d] = 1'b0;
      return;
    end
    if (ack_k != w + 2) begin
      errors++;
      $display("FAIL ack_latency[%0d] got %0d want %0d", d, ack_k, w + 2);
    end
    checks++;
    if ({both, got_port} !== {1'b0, e.port}) begin
      errors++;
      $display("FAIL ack_port[%0d] got both=%b aux=%b want both=0 aux=%b", d, both, got_port, e.port);
    end
    checks++;
    if (strobe != w || wrong != 0 || overlap) begin
      errors++;
      $display("FAIL strobe_width[%0d] got %0d wrong=%0d overlap=%b want %0d 0 0", d, strobe, wrong, overlap, w);
    end
    checks++;
    if (other_at_ack !== other_before) begin
      errors++;
      $display("FAIL other_rdata[%0d] got %h want %h", d, other_at_ack, other_before);
    end
    checks++;
    if (e.we) begin
      if ({hold_pins, dout_at_ack} !== {3'b011, wdata}) begin
        errors++;
        $display("FAIL hold_write[%0d] got pins=%b data=%h want 011 %h", d, hold_pins, dout_at_ack, wdata);
      end
    end else if (rd_at_ack !== e.rdata) begin
      errors++;
      $display("FAIL read_data[%0d] got %h want %h", d, rd_at_ack, e.rdata);
    end
    tick();
    checks++;
    if ({ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], h_ack[d], a_ack[d]} !== 7'b1011000) begin
      errors++;
      $display("FAIL post_hold[%0d] got %b%b%b%b%b%b%b want 1011000", d,
               ceh_n[d], ce2[d], we_n[d], oe_n[d], mem_oe[d], h_ack[d], a_ack[d]);
    end
  endtask

  task automatic test_host_write();
    do_access(0, 1'b0, 1'b1, 17'h00012, 8'h73, 8'h00);
    checks++;
    if (sram[0][8'h12] !== 8'h73) begin
      errors++;
      $display("FAIL host_write_mem got %h want 73", sram[0][8'h12]);
    end
  endtask

  task automatic test_host_read();
    do_access(0, 1'b0, 1'b0, 17'h00012, 8'h00, 8'h73);
  endtask

  task automatic test_aux_read();
    do_access(0, 1'b1, 1'b0, 17'h1FFFF, 8'h00, 8'hA5);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bit bad = 1'b0;
    h_req[0] = 1'b1; h_we[0] = 1'b1; h_addr[0] = 17'h00050; h_wdata[0] = 8'h99;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (!we_n[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_strobe got no we_n low want we_n low");
    end
    rst[0] = 1'b1;
    h_req[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    checks++;
    if ({ceh_n[0], ce2[0], we_n[0], oe_n[0], mem_oe[0], h_ack[0], a_ack[0]} !== 7'b1011000) begin
      errors++;
      $display("FAIL reset_mid_pins got %b%b%b%b%b%b%b want 1011000",
               ceh_n[0], ce2[0], we_n[0], oe_n[0], mem_oe[0], h_ack[0], a_ack[0]);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (h_ack[0] || a_ack[0] || !ceh_n[0]) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle got activity=%b want 0", bad);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int n = 0;
    int last_k = -1;
    bit dbl = 1'b0;
    bit gap_bad = 1'b0;
    bit extra = 1'b0;
    int w = wc(0);
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.we = 1'b1; e.rdata = 8'h00;
      exp_q.push_back(e);
    end
    h_req[0] = 1'b1; h_we[0] = 1'b1; h_addr[0] = 17'h00030; h_wdata[0] = 8'h3A;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 17'h10040; a_wdata[0] = 8'h4B;
    for (int k = 1; k <= 4 * (w + 3) + 20 && n < 4; k++) begin
      tick();
      if (h_ack[0] && a_ack[0]) dbl = 1'b1;
      if (h_ack[0] || a_ack[0]) begin
        e = exp_q.pop_front();
        checks++;
        if (a_ack[0] !== e.port) begin
          errors++;
          $display("FAIL rr_order[%0d] got aux=%b want aux=%b", n, a_ack[0], e.port);
        end
        if (last_k >= 0 && k - last_k != w + 3) gap_bad = 1'b1;
        last_k = k;
        n++;
        if (n == 4) begin
          h_req[0] = 1'b0; a_req[0] = 1'b0;
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_count got %0d want 4", n);
      exp_q.delete();
      h_req[0] = 1'b0; a_req[0] = 1'b0;
    end
    checks++;
    if (dbl || gap_bad) begin
      errors++;
      $display("FAIL rr_spacing got double=%b gap_bad=%b want 0 0", dbl, gap_bad);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (h_ack[0] || a_ack[0] || !ceh_n[0]) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL rr_quiet got activity=%b want 0", extra);
    end
    checks++;
    if ({sram[0][8'h30], sram[0][8'h40]} !== 16'h3A4B) begin
      errors++;
      $display("FAIL rr_mem got %h %h want 3a 4b", sram[0][8'h30], sram[0][8'h40]);
    end
  endtask

  task automatic test_wait_cycles();
    do_access(1, 1'b0, 1'b1, 17'h00022, 8'h3C, 8'h00);
    do_access(1, 1'b1, 1'b0, 17'h00022, 8'h00, 8'h3C);
    do_access(2, 1'b1, 1'b1, 17'h00023, 8'hC3, 8'h00);
    do_access(2, 1'b0, 1'b0, 17'h00023, 8'h00, 8'hC3);
    do_access(2, 1'b1, 1'b0, 17'h1F077, 8'h00, 8'h2D);
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_read();
    test_aux_read();
    test_reset_mid();
    test_round_robin();
    test_wait_cycles();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
